// File: rtl/spi_regif_pkg.sv
// Shared types and frame layout for the SPI slave register interface.
// Frame = R/W bit, then address, then data, all MSB first.
package spi_regif_pkg;

    localparam int unsigned DWIDTH_DEF = 16;
    localparam int unsigned ALINES_DEF = 7;
    localparam int unsigned CMDW       = 1 + ALINES_DEF;
    localparam int unsigned FRAME_LEN  = CMDW + DWIDTH_DEF;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWdata,
        StRdata,
        StDrain
    } regif_state_e;

    function automatic int unsigned cmd_width(input int unsigned alines);
        return 1 + alines;
    endfunction

    // Wide enough to count every bit of the longer frame phase.
    function automatic int unsigned cnt_width(input int unsigned alines,
                                              input int unsigned dwidth);
        int unsigned longest;
        longest = (1 + alines > dwidth) ? 1 + alines : dwidth;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI line, with edge detection
// taken against a third delayed flop.
module spi_sync_edge #(
    parameter logic RstVal = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {3{RstVal}};
        end else begin
            sync_q <= {sync_q[1:0], sig};
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave that turns R/W + address + data frames into single-cycle
// cs/wr strobes for a register bank, with read data shifted back on MISO.
module spi_slave_regif
    import spi_regif_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned ALINES = ALINES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_csn,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              cs,
    output logic              wr,
    output logic [ALINES-1:0] addr,
    output logic [DWIDTH-1:0] din,
    input  logic [DWIDTH-1:0] dout,
    output logic              frame_err
);

    localparam int unsigned CmdW = cmd_width(ALINES);
    localparam int unsigned CntW = cnt_width(ALINES, DWIDTH);

    logic sclk_rise, sclk_fall, sclk_unused_level;
    logic csn_s, csn_rise, csn_fall;
    logic mosi_s, mosi_unused_rise, mosi_unused_fall;

    spi_sync_edge #(.RstVal(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (spi_sclk),
        .level (sclk_unused_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.RstVal(1'b1)) u_sync_csn (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (spi_csn),
        .level (csn_s),
        .rise  (csn_rise),
        .fall  (csn_fall)
    );

    spi_sync_edge #(.RstVal(1'b0)) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (spi_mosi),
        .level (mosi_s),
        .rise  (mosi_unused_rise),
        .fall  (mosi_unused_fall)
    );

    regif_state_e      state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ALINES-1:0] cmd_q, cmd_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              cs_q, cs_d, wr_q, wr_d, ferr_q, ferr_d;
    logic [ALINES-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] din_q, din_d;
    logic              armed_q, armed_d;
    logic [1:0]        flush_q, flush_d;

    logic [CmdW-1:0]   cmd_next;
    logic [DWIDTH-1:0] data_next;

    assign cmd_next  = {cmd_q, mosi_s};
    assign data_next = {data_q[DWIDTH-2:0], mosi_s};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        ferr_d  = ferr_q;
        flush_d = (flush_q == 2'd3) ? flush_q : flush_q + 2'd1;
        // A csn edge seen before the synchronizers have flushed after reset
        // belongs to a frame already in progress; wait for csn to go high.
        armed_d = armed_q | ((flush_q == 2'd3) & csn_s);

        unique case (state_q)
            StIdle: begin
                if (csn_fall && armed_q) begin
                    state_d = StCmd;
                    cnt_d   = '0;
                    ferr_d  = 1'b0;
                end
            end
            StCmd: begin
                if (csn_rise) begin
                    state_d = StIdle;
                    ferr_d  = 1'b1;
                end else if (sclk_rise) begin
                    cmd_d = cmd_next[ALINES-1:0];
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(CmdW - 1)) begin
                        cnt_d = '0;
                        if (cmd_next[CmdW-1]) begin
                            state_d = StWdata;
                        end else begin
                            state_d = StRdata;
                            cs_d    = 1'b1;
                            addr_d  = cmd_next[ALINES-1:0];
                        end
                    end
                end
            end
            StWdata: begin
                if (csn_rise) begin
                    state_d = StIdle;
                    ferr_d  = 1'b1;
                end else if (sclk_rise) begin
                    data_d = data_next;
                    cnt_d  = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(DWIDTH - 1)) begin
                        state_d = StDrain;
                        cs_d    = 1'b1;
                        wr_d    = 1'b1;
                        addr_d  = cmd_q;
                        din_d   = data_next;
                    end
                end
            end
            StRdata: begin
                if (csn_rise) begin
                    state_d = StIdle;
                    ferr_d  = 1'b1;
                end else begin
                    if (cs_q) begin
                        data_d = dout;
                    end
                    // The fall trailing the last command bit must not shift:
                    // the MSB is still waiting for its first data rise.
                    if (sclk_fall && cnt_q != '0) begin
                        data_d = {data_q[DWIDTH-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        cnt_d = cnt_q + CntW'(1);
                        if (cnt_q == CntW'(DWIDTH - 1)) begin
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                if (csn_rise) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
            flush_q <= flush_d;
        end
    end

    assign cs          = cs_q;
    assign wr          = wr_q;
    assign addr        = addr_q;
    assign din         = din_q;
    assign frame_err   = ferr_q;
    assign spi_miso    = (state_q == StRdata && !cs_q) ? data_q[DWIDTH-1] : 1'b0;
    assign spi_miso_oe = ~csn_s;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Bench for spi_slave_regif: table of directed frames, hand-written corner
// sequences, then random frames checked against a register-map model.
module tb_spi_slave_regif;

    localparam int DW = 16;
    localparam int AW = 7;
    localparam int CW = 1 + AW;
    localparam int FW = CW + DW;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          spi_sclk = 1'b0;
    logic          spi_csn  = 1'b1;
    logic          spi_mosi = 1'b0;
    logic          spi_miso, spi_miso_oe, cs, wr, frame_err;
    logic [AW-1:0] addr;
    logic [DW-1:0] din, dout;

    spi_slave_regif #(.DWIDTH(DW), .ALINES(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_sclk    (spi_sclk),
        .spi_csn     (spi_csn),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .cs          (cs),
        .wr          (wr),
        .addr        (addr),
        .din         (din),
        .dout        (dout),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 7'd5) ? 16'h1234 : {a, ~a, 2'b01};
    endfunction

    // Register bank stand-in; dout is garbage whenever cs is low.
    logic [DW-1:0]      bank [2**AW];
    logic [2**AW-1:0]   written = '0;
    logic [DW-1:0]      bank_rd;
    assign bank_rd = written[addr] ? bank[addr] : init_val(addr);
    assign dout    = cs ? bank_rd : ~bank_rd;
    always @(posedge clk) begin
        if (cs && wr) begin
            bank[addr]    <= din;
            written[addr] <= 1'b1;
        end
    end

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } strobe_t;

    strobe_t strobes[$];
    int      viol = 0;
    int      csn_high_cnt = 0;
    logic    cs_prev = 1'b0;

    always @(negedge clk) begin
        if (cs) strobes.push_back({wr, addr, din});
        if (cs && cs_prev) viol++;
        if (wr && !cs) viol++;
        if ((spi_miso || spi_miso_oe) && csn_high_cnt > 4) viol++;
        cs_prev      = cs;
        csn_high_cnt = spi_csn ? csn_high_cnt + 1 : 0;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Master side at sclk = clk/8; MISO sampled just before each data rise.
    task automatic spi_frame(input logic [FW-1:0] frame, input int nbits, input bit raise,
                             output logic [DW-1:0] rx);
        rx      = '0;
        spi_csn = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i < FW) spi_mosi = frame[FW-1-i];
            else        spi_mosi = 1'($urandom);
            wait_clk(4);
            if (i >= CW && i < FW) rx = {rx[DW-2:0], spi_miso};
            spi_sclk = 1'b1;
            wait_clk(4);
            spi_sclk = 1'b0;
        end
        wait_clk(4);
        if (raise) spi_csn = 1'b1;
    endtask

    logic [DW-1:0] ref_mem [2**AW];

    task automatic run_frame(input string name, input logic rw, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input int nbits, input int exp_n,
                             input logic exp_ferr, input logic [DW-1:0] exp_rd,
                             input logic chk_rd);
        logic [DW-1:0] rx;
        strobes.delete();
        spi_frame({rw, a, d}, nbits, 1'b1, rx);
        wait_clk(6);
        check({name, " strobe count"}, strobes.size(), exp_n);
        if (strobes.size() == 1 && exp_n == 1) begin
            check({name, " strobe wr/addr"}, {strobes[0].w, strobes[0].a}, {rw, a});
            if (rw) check({name, " strobe din"}, strobes[0].d, d);
        end
        if (chk_rd) check({name, " miso data"}, rx, exp_rd);
        check({name, " frame_err"}, frame_err, exp_ferr);
        if (rw && nbits >= FW) ref_mem[a] = d;
    endtask

    typedef struct {
        string         name;
        logic          rw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            nbits;
        int            exp_n;
        logic          exp_ferr;
        logic [DW-1:0] exp_rd;
        logic          chk_rd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [DW-1:0] rx;
        logic          rw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            nbits, exp_n;
        bit            full;

        for (int i = 0; i < 2**AW; i++) ref_mem[i] = init_val(AW'(i));

        vecs[0] = '{"wr3",        1'b1, 7'h03, 16'hBEEF, FW,     1, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{"rd5",        1'b0, 7'h05, 16'h0000, FW,     1, 1'b0, 16'h1234, 1'b1};
        vecs[2] = '{"rd3",        1'b0, 7'h03, 16'h0000, FW,     1, 1'b0, 16'hBEEF, 1'b1};
        vecs[3] = '{"wr_short12", 1'b1, 7'h12, 16'hA5A5, 12,     0, 1'b1, 16'h0000, 1'b0};
        vecs[4] = '{"wr_clear",   1'b1, 7'h12, 16'h5A5A, FW,     1, 1'b0, 16'h0000, 1'b0};
        vecs[5] = '{"wr_drain8",  1'b1, 7'h40, 16'hC3C3, FW + 8, 1, 1'b0, 16'h0000, 1'b0};
        vecs[6] = '{"rd40",       1'b0, 7'h40, 16'h0000, FW,     1, 1'b0, 16'hC3C3, 1'b1};
        vecs[7] = '{"rd_short",   1'b0, 7'h22, 16'h0000, 10,     1, 1'b1, 16'h0000, 1'b0};

        #3 rst_n = 1'b0;
        wait_clk(3);
        check("reset outputs", {cs, wr, addr, din, spi_miso, spi_miso_oe, frame_err}, 0);
        rst_n = 1'b1;
        wait_clk(8);
        check("post-reset idle", {cs, wr, addr, din, spi_miso, spi_miso_oe, frame_err}, 0);

        foreach (vecs[i]) begin
            run_frame(vecs[i].name, vecs[i].rw, vecs[i].a, vecs[i].d, vecs[i].nbits,
                      vecs[i].exp_n, vecs[i].exp_ferr, vecs[i].exp_rd, vecs[i].chk_rd);
        end

        // Back-to-back writes with a single clk of csn high between them.
        strobes.delete();
        spi_frame({1'b1, 7'h11, 16'h1111}, FW, 1'b1, rx);
        wait_clk(1);
        spi_frame({1'b1, 7'h21, 16'h2222}, FW, 1'b1, rx);
        wait_clk(6);
        check("b2b strobe count", strobes.size(), 2);
        if (strobes.size() == 2) begin
            check("b2b first", strobes[0], {1'b1, 7'h11, 16'h1111});
            check("b2b second", strobes[1], {1'b1, 7'h21, 16'h2222});
        end
        check("b2b frame_err", frame_err, 0);
        ref_mem[7'h11] = 16'h1111;
        ref_mem[7'h21] = 16'h2222;

        // Reset pulsed at bit 10 of a write; the rest of that frame is ignored.
        strobes.delete();
        spi_frame({1'b1, 7'h55, 16'h1357}, 10, 1'b0, rx);
        rst_n = 1'b0;
        #1;
        check("mid-frame reset outputs",
              {cs, wr, addr, din, spi_miso, spi_miso_oe, frame_err}, 0);
        wait_clk(3);
        rst_n = 1'b1;
        spi_frame(FW'($urandom), 14, 1'b1, rx);
        wait_clk(6);
        check("reset tail strobes", strobes.size(), 0);
        check("reset tail frame_err", frame_err, 0);
        run_frame("wr7f", 1'b1, 7'h7F, 16'h0F0F, FW, 1, 1'b0, 16'h0000, 1'b0);
        run_frame("rd7f", 1'b0, 7'h7F, 16'h0000, FW, 1, 1'b0, 16'h0F0F, 1'b1);

        for (int k = 0; k < 25; k++) begin
            rw = 1'($urandom);
            a  = AW'($urandom);
            d  = DW'($urandom);
            case ($urandom_range(0, 9))
                0, 1:    nbits = $urandom_range(1, FW - 1);
                2:       nbits = FW + $urandom_range(1, 6);
                default: nbits = FW;
            endcase
            full  = nbits >= FW;
            exp_n = rw ? int'(full) : int'(nbits >= CW);
            run_frame($sformatf("rand%0d", k), rw, a, d, nbits, exp_n, !full, ref_mem[a],
                      !rw && full);
        end

        check("protocol violations", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_regif.md
SPI_SLAVE_REGIF -- requirements
Module: spi_slave_regif

Interface
REQ-001 Parameter DWIDTH, default 16, register data width.
REQ-002 Parameter ALINES, default 7, register address width.
REQ-003 Constraint on parameters: 1+ALINES+DWIDTH frame bits; CMDW = 1+ALINES.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 spi_sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-007 spi_csn  input  1  SPI chip select, active-low, asynchronous.
REQ-008 spi_mosi  input  1  SPI serial data in, MSB first.
REQ-009 spi_miso  output  1  SPI serial data out, MSB first.
REQ-010 spi_miso_oe  output  1  MISO output enable, high only while spi_csn is low.
REQ-011 cs  output  1  register-bank select strobe, one clk wide.
REQ-012 wr  output  1  write qualifier, valid only with cs.
REQ-013 addr  output  ALINES  register address, held stable between strobes.
REQ-014 din  output  DWIDTH  write data to register bank.
REQ-015 dout  input  DWIDTH  read data from register bank, combinationally valid in the cycle cs is high.
REQ-016 frame_err  output  1  sticky flag; set when a frame ends short; cleared by next valid frame start.

Function
REQ-017 spi_sclk, spi_csn, spi_mosi SHALL each pass a 2-flop synchronizer; sclk edges are detected from a third delayed flop.
REQ-018 Supported spi_sclk frequency SHALL be at most clk/8.
REQ-019 Frame: bit 0 = R/W (1 = write), then ALINES address bits, then DWIDTH data bits; all MSB first.
REQ-020 MOSI SHALL be sampled on each detected synchronized sclk rising edge.
REQ-021 FSM states: IDLE, CMD, WDATA, RDATA, DRAIN.
REQ-022 IDLE -> CMD on synchronized csn falling edge; bit counter cleared.
REQ-023 CMD -> WDATA after CMDW bits when R/W=1.
REQ-024 CMD -> RDATA after CMDW bits when R/W=0.
REQ-025 On entry to RDATA: one-cycle strobe cs=1, wr=0, addr=received address; dout captured into the TX shift register in that same cycle.
REQ-026 In RDATA, spi_miso SHALL present TX bit DWIDTH-1 before the first data sclk rising edge; it shifts on each synchronized sclk falling edge.
REQ-027 WDATA -> DRAIN after DWIDTH bits; strobe cs=1, wr=1, addr, din=received data, asserted one clk after the last sample.
REQ-028 RDATA -> DRAIN after DWIDTH sclk rising edges.
REQ-029 DRAIN: further sclk edges are ignored, with no further strobes; -> IDLE on csn rising edge.
REQ-030 A csn rising edge in CMD, WDATA or RDATA SHALL return to IDLE, issue no write strobe, and set frame_err.
REQ-031 A csn falling edge coincident with a pending strobe SHALL not suppress that strobe.
REQ-032 cs SHALL never be high for two consecutive clks; wr SHALL be 0 whenever cs is 0.
REQ-033 spi_miso SHALL be 0 outside RDATA.

Reset
REQ-034 rst_n low SHALL asynchronously force: state IDLE, cs=0, wr=0, addr=0, din=0, spi_miso=0, spi_miso_oe=0, frame_err=0, counters 0, synchronizers to idle (csn=1, sclk=0).
REQ-035 Reset deassertion mid-frame SHALL leave the block in IDLE until the next csn falling edge; the partial frame is discarded.

Structure
REQ-036 State enum, frame layout constants (CMDW, frame length), and the default DWIDTH/ALINES SHALL live in the shared package spi_regif_pkg.
REQ-037 The synchronizer plus edge detector SHALL be a sub-module spi_sync_edge, instantiated once per SPI input.
REQ-038 The block SHALL connect directly to register_main's cs/wr/addr/din/dout ports with no glue logic.

Verification
REQ-039 Write frame 1,0000011,0xBEEF -> exactly one cs=wr=1 strobe with addr=3, din=0xBEEF; no other strobes.
REQ-040 Read addr 5 with dout=0x1234 -> a cs=1, wr=0 strobe with addr=5; MISO bits over 16 sclk = 0x1234 MSB first.
REQ-041 csn raised after 12 bits of a write -> no strobe, frame_err=1; next valid frame clears frame_err.
REQ-042 Write frame followed by 8 extra sclk pulses before csn high -> exactly one strobe; DRAIN held until csn rises.
REQ-043 rst_n pulsed low at bit 10 of a write -> all outputs 0 immediately; no strobe; next full frame to addr 0x7F succeeds.
REQ-044 Back-to-back frames at sclk=clk/8 with 1 clk csn-high gap -> both strobes issued, in order.
